// File: rtl/pin_test_sequencer.sv
// pin_test_sequencer: steps a pushbutton-driven test pattern across a row of
// J3 header pins. The pattern goes IDLE (all off), then WALK (one pin at a
// time, lowest first), then ALL (every pin on), then back to IDLE.
// The raw button is synchronized and debounced, and each accepted rising
// level produces one step.
// Optional feature: define PIN_TEST_AUTO_EN to add an auto-step timer. The
// timer advances WALK and ALL every STEP_CYCLES cycles. IDLE still needs a
// press to start.
module pin_test_sequencer #(
  parameter int NPINS       = 8,
  parameter int DEB_CYCLES  = 1000000,
  parameter int STEP_CYCLES = 50000000,
  localparam int IDXW       = (NPINS > 1) ? $clog2(NPINS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_in,
  output logic [NPINS-1:0] pins_out,
  output logic             led,
  output logic [IDXW-1:0]  pin_idx,
  output logic             press
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NPINS - 1);
  localparam logic [NPINS-1:0] PIN_ONE  = NPINS'(1);

  typedef enum logic [1:0] {IDLE, WALK, ALL} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDXW-1:0] idx_d;
  logic [NPINS-1:0] pins_d;
  logic            led_d;
  logic            sync1;
  logic            sync2;
  logic            deb_level;
  logic            deb_prev;
  logic [DW-1:0]   deb_cnt;
  logic            step;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pb_in;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive disagreeing cycles, and strobe on a rising accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      press    <= deb_level & ~deb_prev;
      if (sync2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sync2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

`ifdef PIN_TEST_AUTO_EN
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] auto_timer;
  logic          auto_tick;

  assign auto_tick = (state_q != IDLE) && (auto_timer == STEP_LAST);
  assign step      = press | auto_tick;

  // Auto-step timer runs only while not in IDLE and restarts on every step
  always_ff @(posedge clk) begin
    if (rst || step || (state_q == IDLE)) begin
      auto_timer <= '0;
    end else begin
      auto_timer <= auto_timer + 1'b1;
    end
  end
`else
  assign step = press;
`endif

  // State register; outputs are registered alongside the state so they change together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pin_idx  <= '0;
      pins_out <= '0;
      led      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pin_idx  <= idx_d;
      pins_out <= pins_d;
      led      <= led_d;
    end
  end

  // Next-state logic: each step advances IDLE -> WALK(0..NPINS-1) -> ALL -> IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = pin_idx;
    if (step) begin
      case (state_q)
        IDLE: begin
          state_d = WALK;
          idx_d   = '0;
        end
        WALK: begin
          if (pin_idx == IDX_LAST) begin
            state_d = ALL;
            idx_d   = '0;
          end else begin
            idx_d = pin_idx + 1'b1;
          end
        end
        ALL: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode for the upcoming state, so the registered outputs match it exactly
  always_comb begin
    pins_d = '0;
    led_d  = 1'b0;
    case (state_d)
      WALK: begin
        pins_d = PIN_ONE << idx_d;
        led_d  = 1'b1;
      end
      ALL: begin
        pins_d = '1;
        led_d  = 1'b1;
      end
      default: begin
        pins_d = '0;
        led_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_test_sequencer.sv
// tb_pin_test_sequencer: directed bench for pin_test_sequencer with
// NPINS=4, DEB_CYCLES=4, STEP_CYCLES=8.
module tb_pin_test_sequencer;

  localparam int NPINS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pb_in;
  logic [NPINS-1:0] pins_out;
  logic             led;
  logic [1:0]       pin_idx;
  logic             press;

  int checks = 0;
  int passes = 0;
  int press_cnt = 0;
  int press_double = 0;
  logic press_prev = 1'b0;

  pin_test_sequencer #(
    .NPINS(NPINS),
    .DEB_CYCLES(4),
    .STEP_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb_in(pb_in),
    .pins_out(pins_out),
    .led(led),
    .pin_idx(pin_idx),
    .press(press)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Press strobe monitor: counts strobes and any strobe lasting more than a cycle
  always @(negedge clk) begin
    if (press === 1'b1) press_cnt++;
    if (press === 1'b1 && press_prev === 1'b1) press_double++;
    press_prev = press;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_once();
    pb_in = 1'b1;
    cycles(10);
    pb_in = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset();
    pb_in = 1'b0;
    rst   = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    checks++; if (pins_out !== 4'b0000) $display("[TB] FAIL reset_pins got %b want 0000", pins_out); else passes++;
    checks++; if (led !== 1'b0) $display("[TB] FAIL reset_led got %b want 0", led); else passes++;
    checks++; if (pin_idx !== 2'd0) $display("[TB] FAIL reset_idx got %0d want 0", pin_idx); else passes++;
    checks++; if (press !== 1'b0) $display("[TB] FAIL reset_press got %b want 0", press); else passes++;
  endtask

  task automatic test_bounce();
    int base;
    base = press_cnt;
    for (int i = 0; i < 10; i++) begin
      pb_in = ~pb_in;
      cycles(2);
    end
    pb_in = 1'b0;
    cycles(20);
    checks++; if (press_cnt - base !== 0) $display("[TB] FAIL bounce_press got %0d want 0", press_cnt - base); else passes++;
    checks++; if (pins_out !== 4'b0000) $display("[TB] FAIL bounce_pins got %b want 0000", pins_out); else passes++;
  endtask

  task automatic test_walk();
    logic [3:0] exp_pins [6];
    logic [1:0] exp_idx [6];
    logic       exp_led [6];
    int base;
    exp_pins = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000};
    exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    exp_led  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      base = press_cnt;
      press_once();
      checks++; if (pins_out !== exp_pins[i]) $display("[TB] FAIL walk_pins[%0d] got %b want %b", i, pins_out, exp_pins[i]); else passes++;
      checks++; if (pin_idx !== exp_idx[i]) $display("[TB] FAIL walk_idx[%0d] got %0d want %0d", i, pin_idx, exp_idx[i]); else passes++;
      checks++; if (led !== exp_led[i]) $display("[TB] FAIL walk_led[%0d] got %b want %b", i, led, exp_led[i]); else passes++;
      checks++; if (press_cnt - base !== 1) $display("[TB] FAIL walk_press[%0d] got %0d want 1", i, press_cnt - base); else passes++;
    end
    checks++; if (press_double !== 0) $display("[TB] FAIL press_width got %0d long strobes want 0", press_double); else passes++;
  endtask

  task automatic test_hold();
    int base;
    base = press_cnt;
    pb_in = 1'b1;
    cycles(100);
    checks++; if (press_cnt - base !== 1) $display("[TB] FAIL hold_press got %0d want 1", press_cnt - base); else passes++;
    checks++; if (pins_out !== 4'b0001) $display("[TB] FAIL hold_pins got %b want 0001", pins_out); else passes++;
    pb_in = 1'b0;
    cycles(20);
    checks++; if (press_cnt - base !== 1) $display("[TB] FAIL hold_release_press got %0d want 1", press_cnt - base); else passes++;
  endtask

  task automatic test_no_auto();
    cycles(40);
    checks++; if (pins_out !== 4'b0001) $display("[TB] FAIL no_auto_pins got %b want 0001", pins_out); else passes++;
    checks++; if (led !== 1'b1) $display("[TB] FAIL no_auto_led got %b want 1", led); else passes++;
  endtask

  task automatic test_reset_mid_walk();
    press_once();
    press_once();
    checks++; if (pins_out !== 4'b0100) $display("[TB] FAIL midwalk_pre_pins got %b want 0100", pins_out); else passes++;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    checks++; if (pins_out !== 4'b0000) $display("[TB] FAIL midwalk_pins got %b want 0000", pins_out); else passes++;
    checks++; if (pin_idx !== 2'd0) $display("[TB] FAIL midwalk_idx got %0d want 0", pin_idx); else passes++;
    checks++; if (led !== 1'b0) $display("[TB] FAIL midwalk_led got %b want 0", led); else passes++;
    cycles(5);
    checks++; if (pins_out !== 4'b0000) $display("[TB] FAIL midwalk_stay_pins got %b want 0000", pins_out); else passes++;
  endtask

  task automatic test_reset_held_button();
    int base;
    pb_in = 1'b1;
    rst   = 1'b1;
    cycles(3);
    base = press_cnt;
    rst  = 1'b0;
    cycles(15);
    checks++; if (press_cnt - base !== 1) $display("[TB] FAIL held_after_reset_press got %0d want 1", press_cnt - base); else passes++;
    checks++; if (pins_out !== 4'b0001) $display("[TB] FAIL held_after_reset_pins got %b want 0001", pins_out); else passes++;
    pb_in = 1'b0;
    cycles(20);
  endtask

  task automatic test_auto();
    logic [3:0] exp_pins [5];
    logic [3:0] prev;
    int n;
    exp_pins = '{4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000};
    pb_in = 1'b1;
    n = 0;
    while (pins_out !== 4'b0001 && n < 30) begin
      cycles(1);
      n++;
    end
    pb_in = 1'b0;
    checks++; if (pins_out !== 4'b0001) $display("[TB] FAIL auto_start_pins got %b want 0001", pins_out); else passes++;
    for (int i = 0; i < 5; i++) begin
      prev = pins_out;
      n = 0;
      while (pins_out === prev && n < 20) begin
        cycles(1);
        n++;
      end
      checks++; if (n !== 8) $display("[TB] FAIL auto_interval[%0d] got %0d want 8", i, n); else passes++;
      checks++; if (pins_out !== exp_pins[i]) $display("[TB] FAIL auto_pins[%0d] got %b want %b", i, pins_out, exp_pins[i]); else passes++;
    end
    cycles(30);
    checks++; if (pins_out !== 4'b0000) $display("[TB] FAIL auto_idle_pins got %b want 0000", pins_out); else passes++;
    checks++; if (led !== 1'b0) $display("[TB] FAIL auto_idle_led got %b want 0", led); else passes++;
  endtask

  // Directed test sequence
  initial begin
    rst   = 1'b1;
    pb_in = 1'b0;
    test_reset();
    test_bounce();
`ifdef PIN_TEST_AUTO_EN
    test_auto();
`else
    test_walk();
    test_hold();
    test_no_auto();
    test_reset_mid_walk();
    test_reset_held_button();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
